eth_intr_ctrl: RTL and testbench

ETH_INTR_CTRL -- requirements
Module: eth_intr_ctrl

---
 rtl/eth_intr_ctrl.sv | 124 ++++++++++++
 tb/tb_eth_intr_ctrl.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/eth_intr_ctrl.sv
// Interrupt controller: per-channel edge/level pending capture, enable masking,
// and a coalescing FSM that holds off the aggregated request by count or time.
module eth_intr_ctrl #(
  parameter int                    num_chan_p      = 2,
  parameter logic [num_chan_p-1:0] edge_mask_p     = '1,
  parameter logic [num_chan_p-1:0] src_reset_val_p = '0,
  parameter int                    cnt_width_p     = 8
) (
  input  logic                   clk_i,
  input  logic                   reset_i,
  input  logic [num_chan_p-1:0]  src_i,
  input  logic [num_chan_p-1:0]  clear_i,
  input  logic [num_chan_p-1:0]  enable_i,
  input  logic                   enable_v_i,
  input  logic [cnt_width_p-1:0] thresh_i,
  input  logic [cnt_width_p-1:0] timeout_i,
  output logic [num_chan_p-1:0]  pending_o,
  output logic                   irq_o
);

  typedef enum logic [1:0] {
    IDLE,
    HOLD,
    FIRE
  } state_e;

  state_e                 state_q, state_d;
  logic [num_chan_p-1:0]  hist_q;
  logic [num_chan_p-1:0]  pend_q, pend_d;
  logic [num_chan_p-1:0]  en_q;
  logic [num_chan_p-1:0]  set_vec;
  logic [num_chan_p-1:0]  masked;
  logic                   any_masked;
  logic                   new_evt;
  logic [cnt_width_p-1:0] timer_q, timer_d;
  logic [cnt_width_p-1:0] cnt_q, cnt_d;
  logic [cnt_width_p-1:0] timeout_m1;
  logic                   cnt_hit;
  logic                   time_hit;

  // Edge channels OR the new edge in after clearing, so a coincident edge survives the clear.
  always_comb begin
    set_vec = src_i & ~hist_q;
    pend_d  = (edge_mask_p & ((pend_q & ~clear_i) | set_vec))
            | (~edge_mask_p & src_i);
  end

  assign masked     = pend_q & en_q;
  assign any_masked = |masked;
  assign new_evt    = |(edge_mask_p & en_q & pend_d & ~pend_q);

  assign timeout_m1 = timeout_i - cnt_width_p'(1);
  assign time_hit   = (timer_q == timeout_m1);
  assign cnt_hit    = (thresh_i != '0) && (cnt_q >= thresh_i);

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      hist_q <= src_reset_val_p;
      pend_q <= '0;
      en_q   <= '0;
    end else begin
      hist_q <= src_i;
      pend_q <= pend_d;
      if (enable_v_i) begin
        en_q <= enable_i;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q <= IDLE;
      timer_q <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      timer_q <= timer_d;
      cnt_q   <= cnt_d;
    end
  end

  // Timer and event count only live in HOLD; every other path leaves them zero.
  always_comb begin
    state_d = state_q;
    timer_d = '0;
    cnt_d   = '0;
    case (state_q)
      IDLE: begin
        if (any_masked) begin
          if (timeout_i == '0) begin
            state_d = FIRE;
          end else begin
            state_d = HOLD;
            cnt_d   = cnt_width_p'(1);
          end
        end
      end
      HOLD: begin
        if (!any_masked) begin
          state_d = IDLE;
        end else if (time_hit || cnt_hit) begin
          state_d = FIRE;
        end else begin
          timer_d = (timer_q == '1) ? timer_q : timer_q + cnt_width_p'(1);
          if (new_evt && (cnt_q != '1)) begin
            cnt_d = cnt_q + cnt_width_p'(1);
          end else begin
            cnt_d = cnt_q;
          end
        end
      end
      FIRE: begin
        if (!any_masked) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign pending_o = pend_q;
  assign irq_o     = (state_q == FIRE);

endmodule

// File: tb/tb_eth_intr_ctrl.sv
// Directed bench: a 3-channel instance (ch2 level-mode) plus a 1-channel
// instance whose edge history resets high.
module tb_eth_intr_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic [2:0] src, clear, en;
  logic       env;
  logic [7:0] thresh, timeout;
  logic [2:0] pending;
  logic       irq;

  logic       src_b, clear_b, en_b, env_b;
  logic [7:0] thresh_b, timeout_b;
  logic       pending_b;
  logic       irq_b;

  int n_cmp  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  eth_intr_ctrl #(
    .num_chan_p(3), .edge_mask_p(3'b011), .src_reset_val_p(3'b000), .cnt_width_p(8)
  ) u_dut (
    .clk_i(clk), .reset_i(reset), .src_i(src), .clear_i(clear),
    .enable_i(en), .enable_v_i(env), .thresh_i(thresh), .timeout_i(timeout),
    .pending_o(pending), .irq_o(irq)
  );

  eth_intr_ctrl #(
    .num_chan_p(1), .edge_mask_p(1'b1), .src_reset_val_p(1'b1), .cnt_width_p(8)
  ) u_dut_rv (
    .clk_i(clk), .reset_i(reset), .src_i(src_b), .clear_i(clear_b),
    .enable_i(en_b), .enable_v_i(env_b), .thresh_i(thresh_b), .timeout_i(timeout_b),
    .pending_o(pending_b), .irq_o(irq_b)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1; src = '0; clear = '0; en = '0; env = 1'b0;
    thresh = '0; timeout = '0;
    src_b = 1'b1; clear_b = 1'b0; en_b = 1'b0; env_b = 1'b0;
    thresh_b = '0; timeout_b = '0;
    tick(); tick();
    n_cmp++; if (pending !== 3'b000) begin n_fail++; $display("[TB] FAIL reset_pending got=%b exp=000", pending); end
    n_cmp++; if (irq !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_irq got=%b exp=0", irq); end
    reset = 1'b0;
    tick();
    n_cmp++; if (pending !== 3'b000 || irq !== 1'b0) begin n_fail++; $display("[TB] FAIL post_reset got=%b/%b exp=000/0", pending, irq); end
  endtask

  task automatic test_reset_val();
    en_b = 1'b1; env_b = 1'b1;
    tick();
    env_b = 1'b0;
    tick(); tick();
    n_cmp++; if (pending_b !== 1'b0 || irq_b !== 1'b0) begin n_fail++; $display("[TB] FAIL rv_no_edge got=%b/%b exp=0/0", pending_b, irq_b); end
    src_b = 1'b0;
    tick();
    n_cmp++; if (pending_b !== 1'b0) begin n_fail++; $display("[TB] FAIL rv_fall got=%b exp=0", pending_b); end
    src_b = 1'b1;
    tick();
    n_cmp++; if (pending_b !== 1'b1) begin n_fail++; $display("[TB] FAIL rv_rise got=%b exp=1", pending_b); end
    tick();
    n_cmp++; if (irq_b !== 1'b1) begin n_fail++; $display("[TB] FAIL rv_irq got=%b exp=1", irq_b); end
  endtask

  task automatic test_edge_latency();
    en = 3'b111; env = 1'b1;
    tick();
    env = 1'b0;
    src = 3'b001;
    tick();
    n_cmp++; if (pending !== 3'b001) begin n_fail++; $display("[TB] FAIL lat_pending got=%b exp=001", pending); end
    n_cmp++; if (irq !== 1'b0) begin n_fail++; $display("[TB] FAIL lat_irq_early got=%b exp=0", irq); end
    tick();
    n_cmp++; if (irq !== 1'b1) begin n_fail++; $display("[TB] FAIL lat_irq got=%b exp=1", irq); end
    tick(); tick(); tick();
    n_cmp++; if (irq !== 1'b1 || pending !== 3'b001) begin n_fail++; $display("[TB] FAIL lat_hold got=%b/%b exp=1/001", irq, pending); end
    clear = 3'b001;
    tick();
    clear = 3'b000;
    n_cmp++; if (pending !== 3'b000) begin n_fail++; $display("[TB] FAIL clr_pending got=%b exp=000", pending); end
    n_cmp++; if (irq !== 1'b1) begin n_fail++; $display("[TB] FAIL clr_irq_lag got=%b exp=1", irq); end
    tick();
    n_cmp++; if (irq !== 1'b0) begin n_fail++; $display("[TB] FAIL clr_irq got=%b exp=0", irq); end
    src = 3'b000;
    tick();
  endtask

  task automatic test_set_clear_same();
    src = 3'b010; clear = 3'b010;
    tick();
    clear = 3'b000;
    n_cmp++; if (pending !== 3'b010) begin n_fail++; $display("[TB] FAIL setclr_pending got=%b exp=010", pending); end
    tick();
    n_cmp++; if (irq !== 1'b1) begin n_fail++; $display("[TB] FAIL setclr_irq got=%b exp=1", irq); end
    src = 3'b000; clear = 3'b010;
    tick();
    clear = 3'b000;
    tick();
    n_cmp++; if (pending !== 3'b000 || irq !== 1'b0) begin n_fail++; $display("[TB] FAIL setclr_done got=%b/%b exp=000/0", pending, irq); end
  endtask

  task automatic test_level();
    src = 3'b100; clear = 3'b100;
    tick();
    n_cmp++; if (pending !== 3'b100) begin n_fail++; $display("[TB] FAIL level_set got=%b exp=100", pending); end
    src = 3'b000; clear = 3'b000;
    tick();
    n_cmp++; if (pending !== 3'b000 || irq !== 1'b1) begin n_fail++; $display("[TB] FAIL level_follow got=%b/%b exp=000/1", pending, irq); end
    tick();
    n_cmp++; if (irq !== 1'b0) begin n_fail++; $display("[TB] FAIL level_irq_drop got=%b exp=0", irq); end
  endtask

  task automatic test_timeout();
    timeout = 8'd4; thresh = 8'd0;
    src = 3'b001;
    tick();
    n_cmp++; if (pending !== 3'b001 || irq !== 1'b0) begin n_fail++; $display("[TB] FAIL to_pending got=%b/%b exp=001/0", pending, irq); end
    for (int i = 1; i <= 4; i++) begin
      tick();
      n_cmp++; if (irq !== 1'b0) begin n_fail++; $display("[TB] FAIL to_hold%0d got=%b exp=0", i, irq); end
    end
    tick();
    n_cmp++; if (irq !== 1'b1) begin n_fail++; $display("[TB] FAIL to_fire got=%b exp=1", irq); end
    src = 3'b000; clear = 3'b001;
    tick();
    clear = 3'b000;
    tick();
    n_cmp++; if (pending !== 3'b000 || irq !== 1'b0) begin n_fail++; $display("[TB] FAIL to_done got=%b/%b exp=000/0", pending, irq); end
  endtask

  task automatic test_threshold();
    timeout = 8'd100; thresh = 8'd3;
    src = 3'b001;
    tick();
    src = 3'b000;
    tick();
    n_cmp++; if (irq !== 1'b0) begin n_fail++; $display("[TB] FAIL th_e1 got=%b exp=0", irq); end
    src = 3'b010;
    tick();
    n_cmp++; if (pending !== 3'b011 || irq !== 1'b0) begin n_fail++; $display("[TB] FAIL th_e2 got=%b/%b exp=011/0", pending, irq); end
    clear = 3'b001;
    tick();
    clear = 3'b000;
    src = 3'b011;
    n_cmp++; if (pending !== 3'b010 || irq !== 1'b0) begin n_fail++; $display("[TB] FAIL th_e3 got=%b/%b exp=010/0", pending, irq); end
    tick();
    n_cmp++; if (irq !== 1'b0) begin n_fail++; $display("[TB] FAIL th_e4 got=%b exp=0", irq); end
    tick();
    n_cmp++; if (irq !== 1'b1) begin n_fail++; $display("[TB] FAIL th_fire got=%b exp=1", irq); end
    src = 3'b000; clear = 3'b011;
    tick();
    clear = 3'b000;
    tick();
    n_cmp++; if (pending !== 3'b000 || irq !== 1'b0) begin n_fail++; $display("[TB] FAIL th_done got=%b/%b exp=000/0", pending, irq); end
    thresh = 8'd0; timeout = 8'd0;
  endtask

  task automatic test_enable_gating();
    en = 3'b000; env = 1'b1;
    tick();
    env = 1'b0;
    src = 3'b001;
    tick(); tick(); tick();
    n_cmp++; if (pending !== 3'b001 || irq !== 1'b0) begin n_fail++; $display("[TB] FAIL gate_masked got=%b/%b exp=001/0", pending, irq); end
    en = 3'b111; env = 1'b1;
    tick();
    env = 1'b0;
    n_cmp++; if (irq !== 1'b0) begin n_fail++; $display("[TB] FAIL gate_en_lag got=%b exp=0", irq); end
    tick();
    n_cmp++; if (irq !== 1'b1) begin n_fail++; $display("[TB] FAIL gate_en_irq got=%b exp=1", irq); end
    en = 3'b000; env = 1'b1;
    tick();
    env = 1'b0;
    n_cmp++; if (irq !== 1'b1 || pending !== 3'b001) begin n_fail++; $display("[TB] FAIL gate_dis_lag got=%b/%b exp=1/001", irq, pending); end
    tick();
    n_cmp++; if (irq !== 1'b0 || pending !== 3'b001) begin n_fail++; $display("[TB] FAIL gate_dis got=%b/%b exp=0/001", irq, pending); end
  endtask

  task automatic test_reset_mid();
    en = 3'b111; env = 1'b1;
    tick();
    env = 1'b0;
    tick();
    n_cmp++; if (irq !== 1'b1) begin n_fail++; $display("[TB] FAIL mid_fire got=%b exp=1", irq); end
    src = 3'b000; reset = 1'b1;
    tick();
    n_cmp++; if (pending !== 3'b000 || irq !== 1'b0) begin n_fail++; $display("[TB] FAIL mid_reset got=%b/%b exp=000/0", pending, irq); end
    n_cmp++; if (pending_b !== 1'b0) begin n_fail++; $display("[TB] FAIL mid_reset_b got=%b exp=0", pending_b); end
    reset = 1'b0;
    tick();
    src = 3'b001;
    tick(); tick(); tick();
    n_cmp++; if (pending !== 3'b001 || irq !== 1'b0) begin n_fail++; $display("[TB] FAIL mid_en_cleared got=%b/%b exp=001/0", pending, irq); end
    n_cmp++; if (pending_b !== 1'b0 || irq_b !== 1'b0) begin n_fail++; $display("[TB] FAIL mid_rv_no_edge got=%b/%b exp=0/0", pending_b, irq_b); end
  endtask

  initial begin
    test_reset();
    test_reset_val();
    test_edge_latency();
    test_set_clear_same();
    test_level();
    test_timeout();
    test_threshold();
    test_enable_gating();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
